// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// Optional early completion is enabled with DIVIDER_EARLY_DONE_EN.
package seq_restoring_divider_pkg;

  localparam int unsigned DIVIDEND_W_DEF = 8;
  localparam int unsigned DIVISOR_W_DEF  = 4;
  localparam int unsigned CNT_W_DEF      = $clog2(DIVIDEND_W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for an arbitrary iteration count, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake and operand/result bus for seq_restoring_divider.
interface seq_restoring_divider_if #(
  parameter int unsigned DIVIDEND_W = 8,
  parameter int unsigned DIVISOR_W  = 4
);
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/fulladd.sv
// One-bit full adder cell used to build ripple-carry/borrow chains.
module fulladd (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/seq_restoring_divider_cond_sub_stage.sv
// One restoring-division step: trial subtract of {r_in, bit_in} minus divisor,
// keeping the difference when it does not borrow.
module cond_sub_stage #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] r_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] r_out,
  output logic         q_bit
);
  logic [W:0]   a;
  logic [W-1:0] b_inv;
  logic [W-1:0] diff;
  logic [W:0]   carry;

  assign a        = {r_in, bit_in};
  assign b_inv    = ~divisor;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_chain
    fulladd u_fa (
      .a    (a[i]),
      .b    (b_inv[i]),
      .cin  (carry[i]),
      .sum  (diff[i]),
      .cout (carry[i+1])
    );
  end

  // Top bit subtracts the zero-extension (inverted to 1), so only its carry matters.
  assign q_bit = a[W] | carry[W];
  assign r_out = q_bit ? diff : a[W-1:0];
endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Define DIVIDER_EARLY_DONE_EN to finish in one cycle on divisor==0 or dividend<divisor.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF
) (
  input logic                    clk,
  input logic                    rst,
  seq_restoring_divider_if.slave bus
);
  localparam int unsigned CNT_W = cnt_width(DIVIDEND_W);

  state_t                state_q, state_n;
  logic [CNT_W-1:0]      cnt_q, cnt_n;
  logic [DIVISOR_W-1:0]  r_q, r_n;
  logic [DIVIDEND_W-1:0] q_q, q_n;
  logic [DIVISOR_W-1:0]  dsr_q, dsr_n;
  logic [DIVIDEND_W-1:0] quo_q, quo_n;
  logic [DIVISOR_W-1:0]  rem_q, rem_n;
  logic                  dz_q, dz_n;
  logic [DIVISOR_W-1:0]  stage_r;
  logic                  stage_q;
`ifdef DIVIDER_EARLY_DONE_EN
  logic                  early_q, early_n;
`endif

  cond_sub_stage #(.W(DIVISOR_W)) u_stage (
    .r_in    (r_q),
    .bit_in  (q_q[DIVIDEND_W-1]),
    .divisor (dsr_q),
    .r_out   (stage_r),
    .q_bit   (stage_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
`ifdef DIVIDER_EARLY_DONE_EN
      early_q <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      r_q     <= r_n;
      q_q     <= q_n;
      dsr_q   <= dsr_n;
      quo_q   <= quo_n;
      rem_q   <= rem_n;
      dz_q    <= dz_n;
`ifdef DIVIDER_EARLY_DONE_EN
      early_q <= early_n;
`endif
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    r_n     = r_q;
    q_n     = q_q;
    dsr_n   = dsr_q;
    quo_n   = quo_q;
    rem_n   = rem_q;
    dz_n    = dz_q;
`ifdef DIVIDER_EARLY_DONE_EN
    early_n = early_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          dsr_n   = bus.divisor;
          r_n     = '0;
          q_n     = bus.dividend;
          cnt_n   = CNT_W'(DIVIDEND_W - 1);
          dz_n    = 1'b0;
          state_n = RUN;
`ifdef DIVIDER_EARLY_DONE_EN
          early_n = (bus.divisor == '0) ||
                    (bus.dividend < DIVIDEND_W'(bus.divisor));
`endif
        end
      end
      RUN: begin
        r_n   = stage_r;
        q_n   = {q_q[DIVIDEND_W-2:0], stage_q};
        cnt_n = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          quo_n   = q_n;
          rem_n   = stage_r;
          dz_n    = (dsr_q == '0);
          state_n = DONE;
        end
`ifdef DIVIDER_EARLY_DONE_EN
        // Shortcut: q_q still holds the untouched dividend on this single RUN edge.
        if (early_q) begin
          quo_n = '0;
          if (dsr_q == '0) quo_n = '1;
          rem_n   = q_q[DIVISOR_W-1:0];
          dz_n    = (dsr_q == '0);
          state_n = DONE;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: vector table, handshake corner
// cases, random operands against an arithmetic model, exhaustive identity sweep.
module tb_seq_restoring_divider;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  seq_restoring_divider_if #(.DIVIDEND_W(8), .DIVISOR_W(4)) bus ();

  seq_restoring_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] a, input logic [3:0] b);
`ifdef DIVIDER_EARLY_DONE_EN
    if (b == 4'd0 || a < {4'd0, b}) return 1;
`endif
    return 8;
  endfunction

  task automatic ref_div(input logic [7:0] a, input logic [3:0] b,
                         output logic [7:0] q, output logic [3:0] r, output logic dz);
    if (b == 4'd0) begin
      q = 8'hFF; r = a[3:0]; dz = 1'b1;
    end else begin
      q = a / {4'd0, b}; r = 4'(a % {4'd0, b}); dz = 1'b0;
    end
  endtask

  task automatic start_op(input logic [7:0] a, input logic [3:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 4'($urandom);
  endtask

  task automatic wait_done(input logic [7:0] q_hold, input logic [3:0] r_hold, output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done !== 1'b1) begin
        check("busy_while_running", bus.busy, 1);
        check("quotient_stable", bus.quotient, q_hold);
        check("remainder_stable", bus.remainder, r_hold);
      end
    end
    if (lat >= 40) check("done_timeout", bus.done, 1);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                        output logic [7:0] q, output logic [3:0] r, output logic dz, output int lat);
    logic [7:0] qh;
    logic [3:0] rh;
    qh = bus.quotient;
    rh = bus.remainder;
    start_op(a, b);
    check("accept_busy", bus.busy, 1);
    check("accept_done_clear", bus.done, 0);
    wait_done(qh, rh, lat);
    q = bus.quotient; r = bus.remainder; dz = bus.div_zero;
    check("done_busy_low", bus.busy, 0);
  endtask

  initial begin
    vec_t       vecs[8];
    logic [7:0] q, eq;
    logic [3:0] r, er;
    logic       dz, edz;
    int         lat, e;

    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0};
    vecs[1] = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0};
    vecs[2] = '{8'd42,  4'd0,  8'd255, 4'd10, 1'b1};
    vecs[3] = '{8'd9,   4'd3,  8'd3,   4'd0,  1'b0};
    vecs[4] = '{8'd0,   4'd5,  8'd0,   4'd0,  1'b0};
    vecs[5] = '{8'd14,  4'd15, 8'd0,   4'd14, 1'b0};
    vecs[6] = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0};
    vecs[7] = '{8'd100, 4'd9,  8'd11,  4'd1,  1'b0};

    rst = 1'b1; bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_quotient", bus.quotient, 0);
    check("reset_remainder", bus.remainder, 0);
    check("reset_div_zero", bus.div_zero, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, q, r, dz, lat);
      check($sformatf("vec%0d_quotient", i), q, vecs[i].q);
      check($sformatf("vec%0d_remainder", i), r, vecs[i].r);
      check($sformatf("vec%0d_div_zero", i), dz, vecs[i].dz);
      check($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].a, vecs[i].b));
    end

    // Back-to-back from DONE: the accept happens on the very next edge.
    run_op(8'd255, 4'd15, q, r, dz, lat);
    check("b2b_first_quotient", q, 17);
    run_op(8'd225, 4'd15, q, r, dz, lat);
    check("b2b_second_quotient", q, 15);
    check("b2b_second_remainder", r, 0);
    check("b2b_second_latency", lat, 8);

    // start while busy must be ignored.
    start_op(8'd100, 4'd9);
    e = 0;
    repeat (2) begin @(posedge clk); #1; e++; end
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 4'd5;
    @(posedge clk);
    #1;
    e++;
    bus.start = 1'b0;
    check("ignored_start_busy", bus.busy, 1);
    wait_done(8'd15, 4'd0, lat);
    check("ignored_start_quotient", bus.quotient, 11);
    check("ignored_start_remainder", bus.remainder, 1);
    check("ignored_start_latency", e + lat, 8);

    // Reset mid-run discards everything.
    start_op(8'd100, 4'd9);
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_quotient", bus.quotient, 0);
    check("midrst_remainder", bus.remainder, 0);
    check("midrst_div_zero", bus.div_zero, 0);
    repeat (2) begin @(posedge clk); #1; end
    check("midrst_stays_idle", bus.busy | bus.done, 0);
    run_op(8'd9, 4'd3, q, r, dz, lat);
    check("after_rst_quotient", q, 3);
    check("after_rst_remainder", r, 0);

    for (int i = 0; i < 300; i++) begin
      logic [7:0] a;
      logic [3:0] b;
      a = 8'($urandom);
      b = (i % 16 == 0) ? 4'd0 : 4'($urandom);
      ref_div(a, b, eq, er, edz);
      run_op(a, b, q, r, dz, lat);
      check($sformatf("rand_q %0d/%0d", a, b), q, eq);
      check($sformatf("rand_r %0d/%0d", a, b), r, er);
      check($sformatf("rand_dz %0d/%0d", a, b), dz, edz);
      check($sformatf("rand_lat %0d/%0d", a, b), lat, exp_lat(a, b));
    end

    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_op(8'(a), 4'(b), q, r, dz, lat);
        check($sformatf("sweep_identity %0d/%0d", a, b), 32'(q) * 32'(b) + 32'(r), a);
        check($sformatf("sweep_rem_lt %0d/%0d", a, b), (32'(r) < b) ? 1 : 0, 1);
      end
    end

    for (int m = 0; m < 16; m++) begin
      for (int d = 1; d < 16; d++) begin
        run_op(8'(m * d), 4'(d), q, r, dz, lat);
        check($sformatf("product_recover %0d*%0d", m, d), q, m);
        check($sformatf("product_rem %0d*%0d", m, d), r, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
